// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture block.
// Optional hex letters are enabled by defining SEG7_HEX_EN (see seg7_to_val).
package seg7_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;
    localparam logic [6:0] PAT_A = 7'h77;
    localparam logic [6:0] PAT_B = 7'h7C;
    localparam logic [6:0] PAT_C = 7'h39;
    localparam logic [6:0] PAT_D = 7'h5E;
    localparam logic [6:0] PAT_E = 7'h79;
    localparam logic [6:0] PAT_F = 7'h71;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_to_val.sv
// Combinational segment-pattern decoder: pattern -> {value, legal, is_blank}.
// Hex letters A-F count as legal only when SEG7_HEX_EN is defined.
module seg7_to_val
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] val_o,
    output logic       legal_o,
    output logic       is_blank_o
);

`ifdef SEG7_HEX_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    // Table lookup; blank is reported separately and is not a legal value
    always_comb begin
        val_o      = 4'd0;
        legal_o    = 1'b0;
        is_blank_o = 1'b0;
        case (pat_i)
            PAT_0:     begin val_o = 4'd0; legal_o = 1'b1; end
            PAT_1:     begin val_o = 4'd1; legal_o = 1'b1; end
            PAT_2:     begin val_o = 4'd2; legal_o = 1'b1; end
            PAT_3:     begin val_o = 4'd3; legal_o = 1'b1; end
            PAT_4:     begin val_o = 4'd4; legal_o = 1'b1; end
            PAT_5:     begin val_o = 4'd5; legal_o = 1'b1; end
            PAT_6:     begin val_o = 4'd6; legal_o = 1'b1; end
            PAT_7:     begin val_o = 4'd7; legal_o = 1'b1; end
            PAT_8:     begin val_o = 4'd8; legal_o = 1'b1; end
            PAT_9:     begin val_o = 4'd9; legal_o = 1'b1; end
            PAT_A:     begin val_o = 4'hA; legal_o = HEX_EN; end
            PAT_B:     begin val_o = 4'hB; legal_o = HEX_EN; end
            PAT_C:     begin val_o = 4'hC; legal_o = HEX_EN; end
            PAT_D:     begin val_o = 4'hD; legal_o = HEX_EN; end
            PAT_E:     begin val_o = 4'hE; legal_o = HEX_EN; end
            PAT_F:     begin val_o = 4'hF; legal_o = HEX_EN; end
            PAT_BLANK: begin is_blank_o = 1'b1; end
            default:   begin legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Debounces strobed seven-segment samples and emits each newly stable digit
// through a one-entry output buffer. Hex digits need SEG7_HEX_EN defined.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       seg_strobe,
    input  logic       out_ready,
    input  logic       clr_status,
    output logic [3:0] out_val,
    output logic       out_valid,
    output logic       blank,
    output logic       bad,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] STABLE_Q = CNT_W'(STABLE_CNT);

    state_e           state_q, state_d;
    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [3:0]       out_val_q, out_val_d;
    logic             out_valid_q, out_valid_d;
    logic             blank_q, blank_d;
    logic             bad_q, bad_d;
    logic             overrun_q, overrun_d;
    logic             accept_s, push_s, ovr_set_s;
    logic [3:0]       dec_val_s;
    logic             dec_legal_s, dec_blank_s;

    seg7_to_val u_dec (
        .pat_i      (cand_q),
        .val_o      (dec_val_s),
        .legal_o    (dec_legal_s),
        .is_blank_o (dec_blank_s)
    );

    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Qualification FSM: a pattern is accepted once, on reaching STABLE_CNT matches
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        if (seg_strobe) begin
            case (state_q)
                IDLE: begin
                    cand_d  = seg_in;
                    cnt_d   = CNT_ONE;
                    state_d = QUAL;
                end
                QUAL: begin
                    if (seg_in == cand_q) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == STABLE_Q) begin
                            accept_s = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            state_d = QUAL;
                        end
                    end else begin
                        cand_d = seg_in;
                        cnt_d  = CNT_ONE;
                    end
                end
                HOLD: begin
                    if (seg_in != cand_q) begin
                        cand_d  = seg_in;
                        cnt_d   = CNT_ONE;
                        state_d = QUAL;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Accept side effects: blank level, bad pulse, output buffer and overrun flag
    always_comb begin
        out_val_d   = out_val_q;
        out_valid_d = out_valid_q;
        blank_d     = blank_q;
        bad_d       = 1'b0;
        overrun_d   = overrun_q;
        ovr_set_s   = 1'b0;
        push_s      = accept_s & dec_legal_s;
        if (accept_s) begin
            if (dec_blank_s) begin
                blank_d = 1'b1;
            end else if (dec_legal_s) begin
                blank_d = 1'b0;
            end else begin
                bad_d = 1'b1;
            end
        end else begin
            bad_d = 1'b0;
        end
        if (push_s) begin
            if (!out_valid_q || out_ready) begin
                out_val_d   = dec_val_s;
                out_valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 7'h00;
            cnt_q       <= '0;
            out_val_q   <= 4'd0;
            out_valid_q <= 1'b0;
            blank_q     <= 1'b0;
            bad_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            out_val_q   <= out_val_d;
            out_valid_q <= out_valid_d;
            blank_q     <= blank_d;
            bad_q       <= bad_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_val   = out_val_q;
    assign out_valid = out_valid_q;
    assign blank     = blank_q;
    assign bad       = bad_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus random
// stimulus, all checked every cycle against a run-length behavioural model.
module tb_seg7_capture;

    localparam int STABLE = 3;

    logic       clk = 1'b0;
    logic       rst, seg_strobe, out_ready, clr_status;
    logic [6:0] seg_in;
    logic [3:0] out_val;
    logic       out_valid, blank, bad, overrun;

    seg7_capture #(.STABLE_CNT(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_strobe(seg_strobe),
        .out_ready(out_ready), .clr_status(clr_status), .out_val(out_val),
        .out_valid(out_valid), .blank(blank), .bad(bad), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    // Model: a pattern is accepted exactly when its run of identical strobes reaches STABLE
    logic [6:0] tbl [0:15];
    int         n_legal;
    logic [6:0] m_last;
    int         m_run;
    logic [3:0] m_val;
    logic       m_valid, m_blank, m_bad, m_ovr;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit push, ovr_set, accept;
        int kind, v;
        push = 1'b0; ovr_set = 1'b0; accept = 1'b0; kind = 2; v = 0;
        if (rst) begin
            m_last = 7'h00; m_run = 0; m_val = 4'd0;
            m_valid = 1'b0; m_blank = 1'b0; m_bad = 1'b0; m_ovr = 1'b0;
        end else begin
            if (seg_strobe) begin
                if (m_run > 0 && seg_in == m_last) m_run++;
                else begin m_last = seg_in; m_run = 1; end
                accept = (m_run == STABLE);
            end
            if (accept) begin
                if (m_last == 7'h00) kind = 1;
                for (int i = 0; i < n_legal; i++)
                    if (tbl[i] == m_last) begin kind = 0; v = i; end
            end
            m_bad = accept && (kind == 2);
            if (accept && kind == 1) m_blank = 1'b1;
            if (accept && kind == 0) begin m_blank = 1'b0; push = 1'b1; end
            if (push) begin
                if (!m_valid || out_ready) begin m_val = 4'(v); m_valid = 1'b1; end
                else ovr_set = 1'b1;
            end else if (m_valid && out_ready) m_valid = 1'b0;
            if (ovr_set) m_ovr = 1'b1;
            else if (clr_status) m_ovr = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", {7'd0, out_valid}, {7'd0, m_valid});
            chk("m_val",   {4'd0, out_val},   {4'd0, m_val});
            chk("m_blank", {7'd0, blank},     {7'd0, m_blank});
            chk("m_bad",   {7'd0, bad},       {7'd0, m_bad});
            chk("m_ovr",   {7'd0, overrun},   {7'd0, m_ovr});
        end
    end

    task automatic cyc(input logic s, input logic [6:0] p, input logic rdy,
                       input logic clr, input logic r);
        @(negedge clk);
        seg_strobe = s; seg_in = p; out_ready = rdy; clr_status = clr; rst = r;
    endtask

    task automatic strobes(input logic [6:0] p, input int n, input logic rdy);
        for (int k = 0; k < n; k++) cyc(1'b1, p, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] pool [0:6];
        logic [6:0] cur;
        tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F;
        tbl[4] = 7'h66; tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07;
        tbl[8] = 7'h7F; tbl[9] = 7'h6F; tbl[10] = 7'h77; tbl[11] = 7'h7C;
        tbl[12] = 7'h39; tbl[13] = 7'h5E; tbl[14] = 7'h79; tbl[15] = 7'h71;
`ifdef SEG7_HEX_EN
        n_legal = 16;
`else
        n_legal = 10;
`endif
        rst = 1'b1; seg_strobe = 1'b0; seg_in = 7'h00; out_ready = 1'b0; clr_status = 1'b0;
        cyc(1'b1, 7'h3F, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_flags", {5'd0, blank, bad, overrun}, 8'd0);

        // Three matching strobes emit 3 for exactly one cycle
        strobes(7'h4F, 3, 1'b1);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("d3_valid", {7'd0, out_valid}, 8'd1);
        chk("d3_val", {4'd0, out_val}, 8'd3);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("d3_gone", {7'd0, out_valid}, 8'd0);

        // 6D,6D,7D,7D,7D gives a single 6 and no re-emit while held
        strobes(7'h6D, 2, 1'b1);
        strobes(7'h7D, 3, 1'b1);
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("d6_val", {3'd0, out_valid, out_val}, 8'h16);
        strobes(7'h7D, 2, 1'b1);
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("d6_hold", {7'd0, out_valid}, 8'd0);

        // Overrun: 1 held, 2 dropped, then cleared
        strobes(7'h06, 3, 1'b0);
        strobes(7'h5B, 3, 1'b0);
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("ovr_val", {3'd0, out_valid, out_val}, 8'h11);
        chk("ovr_set", {7'd0, overrun}, 8'd1);
        cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("ovr_clr", {7'd0, overrun}, 8'd0);
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

        // Hex A: legal only with the optional feature
        strobes(7'h77, 3, 1'b1);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
`ifdef SEG7_HEX_EN
        chk("hexA", {2'd0, bad, out_valid, out_val}, 8'h1A);
`else
        chk("hexA_bad", {6'd0, bad, out_valid}, 8'h2);
`endif
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("bad_pulse", {7'd0, bad}, 8'd0);

        // Blank then 0
        strobes(7'h00, 3, 1'b1);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("blank_on", {6'd0, blank, out_valid}, 8'h2);
        strobes(7'h3F, 3, 1'b1);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("blank_off", {2'd0, blank, out_valid, out_val}, 8'h10);

        // Reset mid-qualification discards progress; strobe under reset ignored
        strobes(7'h7F, 2, 1'b1);
        cyc(1'b1, 7'h7F, 1'b1, 1'b0, 1'b1);
        strobes(7'h7F, 1, 1'b1);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("rst8_none", {7'd0, out_valid}, 8'd0);
        strobes(7'h7F, 2, 1'b1);
        cyc(1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
        chk("rst8_emit", {3'd0, out_valid, out_val}, 8'h18);

        // Random traffic checked by the model
        pool[0] = 7'h3F; pool[1] = 7'h06; pool[2] = 7'h00; pool[3] = 7'h77;
        pool[4] = 7'h6F; pool[5] = 7'h71; pool[6] = 7'h12;
        cur = 7'h3F;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 9) == 0) cur = 7'($urandom_range(0, 127));
                else cur = pool[$urandom_range(0, 6)];
            end
            cyc(1'($urandom_range(0, 1)), cur, 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 299) == 0));
        end
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
